// File: rtl/pixel_scan_scheduler.sv
// Raster-order pixel issuer for the ray generator's hcount/vcount AXI-stream
// inputs, throttled by an in-flight credit counter fed back by ray_done.
module pixel_scan_scheduler #(
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned MAX_INFLIGHT = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [10:0] hcount_axis_tdata,
    output logic        hcount_axis_tvalid,
    input  logic        hcount_axis_tready,
    output logic [9:0]  vcount_axis_tdata,
    output logic        vcount_axis_tvalid,
    input  logic        vcount_axis_tready,
    input  logic        ray_done,
    output logic [7:0]  inflight,
    output logic        credit_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [7:0]  MAX_L  = 8'(MAX_INFLIGHT);

    state_e      state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hvalid_q, hvalid_d;
    logic        vvalid_q, vvalid_d;
    logic        hacc_q, hacc_d;
    logic        vacc_q, vacc_d;
    logic [7:0]  inflight_q, inflight_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cerr_q, cerr_d;

    logic hs_h, hs_v, issue, ret, credit_ok, last_pix;

    always_comb begin
        hs_h      = hvalid_q & hcount_axis_tready;
        hs_v      = vvalid_q & vcount_axis_tready;
        // A pixel completes once each channel has handshaken, now or earlier.
        issue     = (state_q == SCAN) && (hvalid_q || vvalid_q)
                    && (hacc_q || hs_h) && (vacc_q || hs_v);
        ret       = ray_done && (inflight_q != '0);
        last_pix  = (hcount_q == H_LAST) && (vcount_q == V_LAST);
        inflight_d = inflight_q + {7'd0, issue} - {7'd0, ret};
        credit_ok = inflight_d < MAX_L;

        state_d  = state_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hvalid_d = hvalid_q;
        vvalid_d = vvalid_q;
        hacc_d   = hacc_q;
        vacc_d   = vacc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cerr_d   = cerr_q | (ray_done && (inflight_q == '0));

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = SCAN;
                    hcount_d = '0;
                    vcount_d = '0;
                    hacc_d   = 1'b0;
                    vacc_d   = 1'b0;
                    busy_d   = 1'b1;
                    hvalid_d = credit_ok;
                    vvalid_d = credit_ok;
                end
            end
            SCAN: begin
                if (issue) begin
                    hacc_d = 1'b0;
                    vacc_d = 1'b0;
                    if (last_pix) begin
                        state_d  = DRAIN;
                        hvalid_d = 1'b0;
                        vvalid_d = 1'b0;
                    end else begin
                        if (hcount_q == H_LAST) begin
                            hcount_d = '0;
                            vcount_d = vcount_q + 10'd1;
                        end else begin
                            hcount_d = hcount_q + 11'd1;
                        end
                        hvalid_d = credit_ok;
                        vvalid_d = credit_ok;
                    end
                end else if (hvalid_q || vvalid_q) begin
                    if (hs_h) begin
                        hvalid_d = 1'b0;
                        hacc_d   = 1'b1;
                    end
                    if (hs_v) begin
                        vvalid_d = 1'b0;
                        vacc_d   = 1'b1;
                    end
                end else begin
                    hvalid_d = credit_ok;
                    vvalid_d = credit_ok;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            hcount_q   <= '0;
            vcount_q   <= '0;
            hvalid_q   <= 1'b0;
            vvalid_q   <= 1'b0;
            hacc_q     <= 1'b0;
            vacc_q     <= 1'b0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hvalid_q   <= hvalid_d;
            vvalid_q   <= vvalid_d;
            hacc_q     <= hacc_d;
            vacc_q     <= vacc_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cerr_q     <= cerr_d;
        end
    end

    assign hcount_axis_tdata  = hcount_q;
    assign hcount_axis_tvalid = hvalid_q;
    assign vcount_axis_tdata  = vcount_q;
    assign vcount_axis_tvalid = vvalid_q;
    assign inflight           = inflight_q;
    assign frame_busy         = busy_q;
    assign frame_done         = done_q;
    assign credit_err         = cerr_q;

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Directed bench: a small 4x2 frame (dut_a) and an 8x2 frame with a 4-ray
// credit limit (dut_b) for the credit-exhaustion case.
module tb_pixel_scan_scheduler;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic        fs_a = 1'b0, rd_a = 1'b0, hr_a = 1'b0, vr_a = 1'b0;
    logic        busy_a, done_a, hv_a, vv_a, cerr_a;
    logic [10:0] h_a;
    logic [9:0]  v_a;
    logic [7:0]  inf_a;

    logic        fs_b = 1'b0, rd_b = 1'b0;
    logic        busy_b, done_b, hv_b, vv_b, cerr_b;
    logic [10:0] h_b;
    logic [9:0]  v_b;
    logic [7:0]  inf_b;

    pixel_scan_scheduler #(.H_ACTIVE(4), .V_ACTIVE(2), .MAX_INFLIGHT(4)) dut_a (
        .aclk(aclk), .areset(areset), .frame_start(fs_a),
        .frame_busy(busy_a), .frame_done(done_a),
        .hcount_axis_tdata(h_a), .hcount_axis_tvalid(hv_a), .hcount_axis_tready(hr_a),
        .vcount_axis_tdata(v_a), .vcount_axis_tvalid(vv_a), .vcount_axis_tready(vr_a),
        .ray_done(rd_a), .inflight(inf_a), .credit_err(cerr_a)
    );

    pixel_scan_scheduler #(.H_ACTIVE(8), .V_ACTIVE(2), .MAX_INFLIGHT(4)) dut_b (
        .aclk(aclk), .areset(areset), .frame_start(fs_b),
        .frame_busy(busy_b), .frame_done(done_b),
        .hcount_axis_tdata(h_b), .hcount_axis_tvalid(hv_b), .hcount_axis_tready(1'b1),
        .vcount_axis_tdata(v_b), .vcount_axis_tvalid(vv_b), .vcount_axis_tready(1'b1),
        .ray_done(rd_b), .inflight(inf_b), .credit_err(cerr_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        bit fs;
        bit rd;
        bit ev;
        int eh;
        int evc;
        int einf;
        bit ebusy;
        bit edone;
    } vec_t;

    vec_t vec [16];

    initial begin
        // Row k: outputs expected after edge k, then inputs for the following edge.
        vec[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 1'b1, 1, 0, 1, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 2, 0, 2, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 3, 0, 3, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 0, 1, 3, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1, 1, 3, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 2, 1, 3, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 3, 1, 3, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b1, 1'b0};
        vec[11] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b1, 1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        vec[13] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1};
        vec[14] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};

        repeat (3) tick();
        areset = 1'b0;
        tick();

        chk("rst_valid", hv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_inflight", inf_a, 0);
        chk("rst_cerr", cerr_a, 0);

        // Stray ray_done while idle
        rd_a = 1'b1;
        tick();
        rd_a = 1'b0;
        chk("cerr_set", cerr_a, 1);
        chk("cerr_inflight", inf_a, 0);

        // Full 4x2 frame, readies high, ray_done 3 cycles after each issue
        hr_a = 1'b1;
        vr_a = 1'b1;
        for (int unsigned k = 0; k < 16; k++) begin
            chk($sformatf("t%0d_hvalid", k), hv_a, vec[k].ev);
            chk($sformatf("t%0d_vvalid", k), vv_a, vec[k].ev);
            chk($sformatf("t%0d_inflight", k), inf_a, vec[k].einf);
            chk($sformatf("t%0d_busy", k), busy_a, vec[k].ebusy);
            chk($sformatf("t%0d_done", k), done_a, vec[k].edone);
            if (vec[k].ev) begin
                chk($sformatf("t%0d_h", k), h_a, vec[k].eh);
                chk($sformatf("t%0d_v", k), v_a, vec[k].evc);
            end
            fs_a = vec[k].fs;
            rd_a = vec[k].rd;
            tick();
        end
        fs_a = 1'b0;
        rd_a = 1'b0;

        // vcount channel stalled for 5 cycles while hcount is accepted at once
        vr_a = 1'b0;
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("st_hvalid0", hv_a, 1);
        chk("st_vvalid0", vv_a, 1);
        tick();
        chk("st_hvalid_drop", hv_a, 0);
        chk("st_inflight0", inf_a, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            chk("st_vvalid_hold", vv_a, 1);
            chk("st_vdata_hold", v_a, 0);
            chk("st_hvalid_low", hv_a, 0);
            chk("st_inflight_hold", inf_a, 0);
            tick();
        end
        vr_a = 1'b1;
        tick();
        chk("st_inflight1", inf_a, 1);
        chk("st_h1", h_a, 1);
        chk("st_hvalid1", hv_a, 1);
        chk("st_vvalid1", vv_a, 1);

        // Run to pixel (2,1) with matching ray_done, then reset asynchronously
        begin
            bit reached = 1'b0;
            rd_a = 1'b1;
            for (int unsigned i = 0; i < 20 && !reached; i++) begin
                if (hv_a && h_a == 11'd2 && v_a == 10'd1) reached = 1'b1;
                else tick();
            end
            chk("mid_reached", int'(reached), 1);
        end
        chk("mid_inflight", inf_a, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("ar_hvalid", hv_a, 0);
        chk("ar_vvalid", vv_a, 0);
        chk("ar_busy", busy_a, 0);
        chk("ar_inflight", inf_a, 0);
        chk("ar_cerr", cerr_a, 0);
        chk("ar_h", h_a, 0);
        chk("ar_v", v_a, 0);
        rd_a = 1'b0;
        hr_a = 1'b0;
        vr_a = 1'b0;
        tick();
        areset = 1'b0;
        tick();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("rs_hvalid", hv_a, 1);
        chk("rs_h", h_a, 0);
        chk("rs_v", v_a, 0);
        chk("rs_busy", busy_a, 1);

        // Credit exhaustion on the 8x2 instance
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        chk("cr_valid_start", hv_b, 1);
        repeat (4) tick();
        chk("cr_hvalid_full", hv_b, 0);
        chk("cr_vvalid_full", vv_b, 0);
        chk("cr_inflight_full", inf_b, 4);
        repeat (2) tick();
        chk("cr_hvalid_wait", hv_b, 0);
        chk("cr_inflight_wait", inf_b, 4);
        rd_b = 1'b1;
        tick();
        rd_b = 1'b0;
        chk("cr_inflight_ret", inf_b, 3);
        chk("cr_hvalid_ret", hv_b, 1);
        chk("cr_h5th", h_b, 4);
        chk("cr_v5th", v_b, 0);
        tick();
        chk("cr_inflight_after", inf_b, 4);
        chk("cr_hvalid_after", hv_b, 0);
        chk("cr_cerr", cerr_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
